// File: rtl/c5_counter.sv
// Registered step counter with programmable step, inclusive limit and wrap/saturate
// boundary handling; flags each boundary crossing with a one-cycle terminal-count pulse.
module c5_counter #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      STEP_W    = 8,
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              I_clk,
    input  logic              I_reset_n,
    input  logic              I_load,
    input  logic [WIDTH-1:0]  I_load_val,
    input  logic              I_en,
    input  logic              I_down,
    input  logic [STEP_W-1:0] I_step,
    input  logic [WIDTH-1:0]  I_limit,
    output logic [WIDTH-1:0]  O_count,
    output logic              O_tc,
    output logic              O_sat
);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_sat;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH:0]   w_sum;
    logic             w_over;
    logic             w_under;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;
    logic             w_sat_nxt;

    assign w_step  = WIDTH'(I_step);
    // One extra bit so a carry out of WIDTH always compares above the limit.
    assign w_sum   = {1'b0, r_count} + {1'b0, w_step};
    assign w_over  = w_sum > {1'b0, I_limit};
    assign w_under = w_step > r_count;

    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        w_sat_nxt   = r_sat;
        if (I_load) begin
            w_count_nxt = I_load_val;
            w_sat_nxt   = 1'b0;
        end else if (I_en && (w_step != '0)) begin
            w_sat_nxt = 1'b0;
            if (!I_down) begin
                if (w_over) begin
                    w_tc_nxt = 1'b1;
                    if (SATURATE) begin
                        w_count_nxt = I_limit;
                        w_sat_nxt   = 1'b1;
                    end else begin
                        w_count_nxt = '0;
                    end
                end else begin
                    w_count_nxt = w_sum[WIDTH-1:0];
                end
            end else begin
                if (w_under) begin
                    w_tc_nxt = 1'b1;
                    if (SATURATE) begin
                        w_count_nxt = '0;
                        w_sat_nxt   = 1'b1;
                    end else begin
                        w_count_nxt = I_limit;
                    end
                end else begin
                    w_count_nxt = r_count - w_step;
                end
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_count <= RESET_VAL;
            r_tc    <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    assign O_count = r_count;
    assign O_tc    = r_tc;
    assign O_sat   = r_sat;

endmodule
